// File: rtl/ip2_scanout_capture_if.sv
// Word push channel from the scan-out capture block to the readout FIFO.
interface ip2_scanout_capture_if #(parameter int WORD_W = 32);
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              fifo_full;

  modport master (output word_data, output word_valid, input fifo_full);
  modport slave  (input word_data, input word_valid, output fifo_full);
endinterface

// File: rtl/ip2_scanout_capture.sv
// Samples the ASIC scan_out pin once per bxclk period, packs bits LSB-first into
// words for the readout FIFO, and counts mismatches against the expected chain bit.
module ip2_scanout_capture #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_enable,
  input  logic [5:0]            i_clk_counter,
  input  logic [5:0]            i_sample_phase,
  input  logic                  i_capture_start,
  input  logic [CNT_W-1:0]      i_bit_cnt_max,
  input  logic                  i_scan_out,
  input  logic                  i_expected_bit,
  output logic                  o_expected_shift,
  output logic [CNT_W-1:0]      o_mismatch_cnt,
  output logic                  o_overflow,
  output logic                  o_status_done,
  output logic [2:0]            o_sm_state,
  ip2_scanout_capture_if.master fifo_if
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_CAPTURE = 3'd2,
    S_FLUSH   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int PACK_W = $clog2(WORD_W + 1);
  localparam logic [PACK_W-1:0] LAST_IDX = PACK_W'(WORD_W - 1);

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [PACK_W-1:0]   r_pack_cnt;
  logic [WORD_W-1:0]   r_shift;
  logic [WORD_W-1:0]   r_word_data;
  logic                r_word_valid;
  logic [CNT_W-1:0]    r_mismatch_cnt;
  logic                r_overflow;
  logic                r_status_done;

  logic                w_clear;
  logic                w_match;
  logic                w_sample;
  logic                w_start;
  logic                w_word_full;
  logic                w_last_bit;
  logic [CNT_W-1:0]    w_bit_next;
  logic [WORD_W-1:0]   w_shift_new;

  assign w_clear     = reset || !i_enable;
  assign w_match     = (i_clk_counter == i_sample_phase);
  assign w_sample    = (r_state == S_CAPTURE) && w_match;
  assign w_start     = (r_state == S_IDLE) && i_capture_start;
  assign w_bit_next  = r_bit_cnt + CNT_W'(1);
  assign w_word_full = (r_pack_cnt == LAST_IDX);
  assign w_last_bit  = (w_bit_next == i_bit_cnt_max);
  assign w_shift_new = r_shift | (WORD_W'(i_scan_out) << r_pack_cnt);

  always_ff @(posedge clk) begin
    if (w_clear) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_capture_start) w_next = S_ARM;
      S_ARM: begin
        if (i_bit_cnt_max == '0) w_next = S_DONE;
        else if (w_match)        w_next = S_CAPTURE;
      end
      S_CAPTURE: if (w_sample && w_last_bit) w_next = w_word_full ? S_DONE : S_FLUSH;
      S_FLUSH:   w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // A word (full, or the final partial one) is latched on the sample edge that
  // completes it, so word_valid lands one clk after that sample.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_bit_cnt      <= '0;
      r_pack_cnt     <= '0;
      r_shift        <= '0;
      r_word_data    <= '0;
      r_word_valid   <= 1'b0;
      r_mismatch_cnt <= '0;
      r_overflow     <= 1'b0;
      r_status_done  <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (r_word_valid && fifo_if.fifo_full) r_overflow <= 1'b1;
      if (w_start) begin
        r_bit_cnt      <= '0;
        r_pack_cnt     <= '0;
        r_shift        <= '0;
        r_mismatch_cnt <= '0;
        r_overflow     <= 1'b0;
        r_status_done  <= 1'b0;
      end
      if (w_sample) begin
        r_bit_cnt <= w_bit_next;
        if ((i_scan_out != i_expected_bit) && (r_mismatch_cnt != '1))
          r_mismatch_cnt <= r_mismatch_cnt + CNT_W'(1);
        if (w_word_full || w_last_bit) begin
          r_word_data  <= w_shift_new;
          r_word_valid <= 1'b1;
          r_shift      <= '0;
          r_pack_cnt   <= '0;
        end else begin
          r_shift    <= w_shift_new;
          r_pack_cnt <= r_pack_cnt + PACK_W'(1);
        end
      end
      if ((w_next == S_DONE) && (r_state != S_DONE)) r_status_done <= 1'b1;
    end
  end

  assign o_expected_shift   = w_sample && !w_clear;
  assign o_mismatch_cnt     = r_mismatch_cnt;
  assign o_overflow         = r_overflow;
  assign o_status_done      = r_status_done;
  assign o_sm_state         = r_state;
  assign fifo_if.word_data  = r_word_data;
  assign fifo_if.word_valid = r_word_valid;

endmodule

// File: tb/tb_ip2_scanout_capture.sv
// Directed bench for ip2_scanout_capture: expected words are queued per capture and
// checked by an independent monitor whenever word_valid is seen.
`timescale 1ns/1ps
module tb_ip2_scanout_capture;
  localparam int PER = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [5:0]  clk_counter;
  logic [5:0]  sample_phase = 6'd5;
  logic        capture_start = 1'b0;
  logic [10:0] bit_cnt_max = '0;
  logic        scan_out;
  logic        expected_bit;
  logic        expected_shift;
  logic [10:0] mismatch_cnt;
  logic        overflow;
  logic        status_done;
  logic [2:0]  sm_state;

  ip2_scanout_capture_if #(.WORD_W(32)) fifo_if ();

  ip2_scanout_capture dut (
    .clk             (clk),
    .reset           (reset),
    .i_enable        (enable),
    .i_clk_counter   (clk_counter),
    .i_sample_phase  (sample_phase),
    .i_capture_start (capture_start),
    .i_bit_cnt_max   (bit_cnt_max),
    .i_scan_out      (scan_out),
    .i_expected_bit  (expected_bit),
    .o_expected_shift(expected_shift),
    .o_mismatch_cnt  (mismatch_cnt),
    .o_overflow      (overflow),
    .o_status_done   (status_done),
    .o_sm_state      (sm_state),
    .fifo_if         (fifo_if.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int shift_count = 0;
  int shift_base = 0;
  int valid_cnt = 0;
  int valid_base = 0;
  int mode = 0;
  bit ovf_mode = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic void pat(input int m, input int i, output logic s, output logic e);
    case (m)
      0: begin s = (i % 2 == 0); e = s; end
      1: begin s = 1'b1; e = 1'b1; end
      2: begin s = (i == 0 || i == 100 || i == 1535); e = 1'b0; end
      3: begin s = ((i / 32) % 2 == 1); e = s; end
      default: begin s = 1'b0; e = 1'b0; end
    endcase
  endfunction

  // Phase counter, chain model and fifo_full, all updated just after the clock edge.
  initial begin : driver
    static logic sh;
    static logic s, e;
    clk_counter = '0;
    pat(0, 0, s, e);
    scan_out = s;
    expected_bit = e;
    fifo_if.fifo_full = 1'b0;
    forever begin
      @(negedge clk);
      sh = expected_shift;
      @(posedge clk);
      #1;
      clk_counter = (clk_counter == 6'(PER - 1)) ? 6'd0 : clk_counter + 6'd1;
      if (sh) shift_count++;
      pat(mode, shift_count - shift_base, s, e);
      scan_out = s;
      expected_bit = e;
      fifo_if.fifo_full = ovf_mode && (valid_cnt - valid_base == 2);
    end
  end

  initial begin : monitor
    static logic [31:0] w;
    forever begin
      @(negedge clk);
      if (fifo_if.word_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected word_valid: got word 0x%08h, required no word", fifo_if.word_data);
        end else begin
          w = exp_q.pop_front();
          check("word_data", fifo_if.word_data, w);
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1;
    capture_start = 1'b1;
    @(posedge clk); #1;
    capture_start = 1'b0;
  endtask

  task automatic run_capture(input string tag, input int max, input int m, input bit ovf,
                             input int restart_at, input int exp_words, input int exp_mis,
                             input bit exp_ovf, output int cyc);
    bit done;
    bit_cnt_max = 11'(max);
    mode = m;
    ovf_mode = ovf;
    shift_base = shift_count;
    valid_base = valid_cnt;
    pulse_start();
    done = 1'b0;
    cyc = 0;
    while (!done && cyc < (max + 2) * PER + 20) begin
      @(negedge clk);
      cyc++;
      capture_start = (restart_at > 0 && cyc == restart_at);
      if (capture_start) check({tag, " state at restart"}, sm_state, 3'd2);
      if (status_done) done = 1'b1;
    end
    capture_start = 1'b0;
    check({tag, " done reached"}, done, 1'b1);
    check({tag, " state DONE"}, sm_state, 3'd4);
    repeat (3) @(negedge clk);
    check({tag, " words left"}, exp_q.size(), 0);
    check({tag, " word_valid count"}, valid_cnt - valid_base, exp_words);
    check({tag, " expected_shift count"}, shift_count - shift_base, max);
    check({tag, " mismatch_cnt"}, mismatch_cnt, exp_mis);
    check({tag, " overflow"}, overflow, exp_ovf);
    check({tag, " status_done held"}, status_done, 1'b1);
    check({tag, " state IDLE"}, sm_state, 3'd0);
    ovf_mode = 1'b0;
    exp_q.delete();
  endtask

  initial begin : main
    int cyc;
    int waited;
    repeat (3) @(negedge clk);
    check("reset state", sm_state, 3'd0);
    check("reset word_valid", fifo_if.word_valid, 1'b0);
    check("reset mismatch", mismatch_cnt, 0);
    check("reset status_done", status_done, 1'b0);
    reset = 1'b0;

    // Full chain, alternating 1,0, with a stray capture_start mid-capture.
    repeat (24) exp_q.push_back(32'h5555_5555);
    run_capture("chain768", 768, 0, 1'b0, 100, 24, 0, 1'b0, cyc);

    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_00FF);
    run_capture("flush40", 40, 1, 1'b0, 0, 2, 0, 1'b0, cyc);

    for (int i = 0; i < 48; i++) begin
      if (i == 0)       exp_q.push_back(32'h0000_0001);
      else if (i == 3)  exp_q.push_back(32'h0000_0010);
      else if (i == 47) exp_q.push_back(32'h8000_0000);
      else              exp_q.push_back(32'h0);
    end
    run_capture("errors1536", 1536, 2, 1'b0, 0, 48, 3, 1'b0, cyc);

    exp_q.push_back(32'h0);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hFFFF_FFFF);
    run_capture("overflow128", 128, 3, 1'b1, 0, 4, 0, 1'b1, cyc);

    // Zero length; its capture_start must also clear the previous overflow.
    run_capture("zero", 0, 0, 1'b0, 0, 0, 0, 1'b0, cyc);
    check("zero DONE latency ok", cyc <= 2, 1'b1);

    // Abort after 50 of 768 bits: only the first word may appear.
    exp_q.push_back(32'h5555_5555);
    bit_cnt_max = 11'd768;
    mode = 0;
    shift_base = shift_count;
    valid_base = valid_cnt;
    pulse_start();
    waited = 0;
    while (shift_count - shift_base < 50 && waited < 60 * PER) begin
      @(negedge clk);
      waited++;
    end
    check("abort reached bit 50", shift_count - shift_base >= 50, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("abort state", sm_state, 3'd0);
    check("abort word_data", fifo_if.word_data, 32'h0);
    check("abort word_valid", fifo_if.word_valid, 1'b0);
    check("abort expected_shift", expected_shift, 1'b0);
    check("abort mismatch", mismatch_cnt, 0);
    check("abort status_done", status_done, 1'b0);
    check("abort overflow", overflow, 1'b0);
    reset = 1'b0;
    repeat (40 * PER) @(negedge clk);
    check("abort word count", valid_cnt - valid_base, 1);
    check("abort idle after", sm_state, 3'd0);
    exp_q.delete();

    repeat (24) exp_q.push_back(32'h5555_5555);
    run_capture("after_abort", 768, 0, 1'b0, 0, 24, 0, 1'b0, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
